// File: rtl/lvds_frame_tx.sv
// Framed MSB-first serialiser: SYNC, seq, N_WORDS payload, checksum. First bit one cycle after tx_flag.
// No backpressure: payload writes never stall; ticks arriving while a frame is in flight are dropped and counted.
module lvds_frame_tx #(
  parameter int          N_WORDS   = 4,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic        lvds_clk,
  input  logic        rst_n,
  input  logic        tx_flag,
  input  logic [15:0] data_in,
  input  logic        data_wr,
  output logic        tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt
);

  localparam int TOTAL_BITS = 16 * (N_WORDS + 3);
  localparam int CW         = $clog2(TOTAL_BITS);
  localparam int PW         = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [15:0]           mem [N_WORDS];
  logic [PW-1:0]         wr_ptr;
  logic [TOTAL_BITS-1:0] shreg;
  logic [TOTAL_BITS-1:0] frame_img;
  logic [CW-1:0]         bit_cnt;
  logic [15:0]           csum;
  logic                  accept;

  // Whole frame image, checksum included, is built from the live buffer and loaded in one shot.
  always_comb begin
    csum      = frame_cnt;
    frame_img = '0;
    frame_img[TOTAL_BITS-1 -: 16]  = SYNC_WORD;
    frame_img[TOTAL_BITS-17 -: 16] = frame_cnt;
    for (int i = 0; i < N_WORDS; i++) begin
      csum = csum + mem[i];
      frame_img[TOTAL_BITS-33-16*i -: 16] = mem[i];
    end
    frame_img[15:0] = csum;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_flag) begin
          state_d = SEND;
          accept  = 1'b1;
        end
      end
      SEND: begin
        if (bit_cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lvds_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge lvds_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (accept) begin
        shreg     <= frame_img;
        bit_cnt   <= CW'(TOTAL_BITS - 1);
        frame_cnt <= frame_cnt + 16'd1;
      end else if (state_q == SEND) begin
        shreg   <= {shreg[TOTAL_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt - CW'(1);
      end
      // Any tick seen in SEND, including the last-bit cycle, is lost.
      if (state_q == SEND && tx_flag && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge lvds_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < N_WORDS; i++) mem[i] <= '0;
    end else if (data_wr) begin
      mem[wr_ptr] <= data_in;
      wr_ptr      <= (wr_ptr == PW'(N_WORDS - 1)) ? '0 : wr_ptr + PW'(1);
    end
  end

  assign busy    = (state_q == SEND);
  assign tx_en   = busy;
  assign tx_data = tx_en & shreg[TOTAL_BITS-1];

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Randomised bench for lvds_frame_tx against a word-level frame model and a tick-acceptance model.
module tb_lvds_frame_tx;
  localparam int N     = 4;
  localparam int TOTAL = 16 * (N + 3);

  logic        lvds_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        tx_flag  = 1'b0;
  logic [15:0] data_in  = '0;
  logic        data_wr  = 1'b0;
  logic        tx_data, tx_en, busy;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  lvds_frame_tx #(.N_WORDS(N), .SYNC_WORD(16'hEB90)) dut (
    .lvds_clk(lvds_clk), .rst_n(rst_n), .tx_flag(tx_flag), .data_in(data_in),
    .data_wr(data_wr), .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  always #10 lvds_clk = ~lvds_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mbuf [N];
  int          mptr;
  logic [15:0] mfc;
  logic [7:0]  movr;
  logic [15:0] rx [N+3];

  task automatic step();
    @(posedge lvds_clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    mptr = 0;
    mfc  = '0;
    movr = '0;
  endfunction

  function automatic void model_write(logic [15:0] w);
    mbuf[mptr] = w;
    mptr = (mptr + 1) % N;
  endfunction

  task automatic wr(logic [15:0] w);
    data_in = w;
    data_wr = 1'b1;
    step();
    data_wr = 1'b0;
    model_write(w);
  endtask

  // Pulse a tick, capture the serial frame and compare it to the model's word list.
  task automatic run_frame(string name, bit wr_tick, logic [15:0] w_tick, int mid_at, logic [15:0] w_mid);
    logic [15:0] ew [N+3];
    logic [15:0] sum;
    int len, bad_bits, bad_busy;
    ew[0] = 16'hEB90;
    ew[1] = mfc;
    sum   = mfc;
    for (int i = 0; i < N; i++) begin
      ew[2+i] = mbuf[i];
      sum     = sum + mbuf[i];
    end
    ew[N+2] = sum;
    tx_flag = 1'b1;
    if (wr_tick) begin
      data_in = w_tick;
      data_wr = 1'b1;
    end
    step();
    tx_flag = 1'b0;
    data_wr = 1'b0;
    mfc = mfc + 16'd1;
    if (wr_tick) model_write(w_tick);
    len = 0; bad_bits = 0; bad_busy = 0;
    while (tx_en === 1'b1 && len < TOTAL + 20) begin
      if (len < TOTAL) begin
        rx[len/16][15 - len%16] = tx_data;
        if (tx_data !== ew[len/16][15 - len%16]) bad_bits++;
      end
      if (busy !== 1'b1) bad_busy++;
      if (len == mid_at) begin
        data_in = w_mid;
        data_wr = 1'b1;
      end
      step();
      if (len == mid_at) begin
        data_wr = 1'b0;
        model_write(w_mid);
      end
      len++;
    end
    n_cmp++;
    if (len !== TOTAL) begin
      n_bad++;
      $display("FAIL %s tx_en_cycles: got %0d want %0d", name, len, TOTAL);
    end
    n_cmp++;
    if (bad_bits !== 0) begin
      n_bad++;
      $display("FAIL %s frame_bits: got %0d wrong bits want 0", name, bad_bits);
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL %s busy_during_frame: got %0d low cycles want 0", name, bad_busy);
    end
    n_cmp++;
    if ({busy, tx_data} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s idle_after_frame: got busy=%b tx_data=%b want 0 0", name, busy, tx_data);
    end
    n_cmp++;
    if (frame_cnt !== mfc) begin
      n_bad++;
      $display("FAIL %s frame_cnt: got %h want %h", name, frame_cnt, mfc);
    end
  endtask

  task automatic check_word(string name, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Tick patterns; acceptance modelled as "idle if the last accepted frame's TOTAL cycles have elapsed".
  task automatic run_ticks(string name, int ncyc, bit every_cycle);
    int rem, bad_busy, guard;
    bit tick;
    rem = 0; bad_busy = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick = every_cycle || c == 0 || c == 50 || c == 111 || c == 113;
      tx_flag = tick;
      step();
      if (tick && rem == 0) begin
        rem = TOTAL;
        mfc = mfc + 16'd1;
      end else begin
        if (tick && movr != 8'hFF) movr = movr + 8'd1;
        if (rem > 0) rem--;
      end
      if (busy !== (rem > 0)) bad_busy++;
    end
    tx_flag = 1'b0;
    n_cmp++;
    if (overrun_cnt !== movr) begin
      n_bad++;
      $display("FAIL %s overrun_cnt: got %h want %h", name, overrun_cnt, movr);
    end
    guard = 0;
    while (rem > 0 && guard < 400) begin
      step();
      rem--;
      guard++;
      if (busy !== (rem > 0)) bad_busy++;
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL %s busy_profile: got %0d wrong cycles want 0", name, bad_busy);
    end
    n_cmp++;
    if (frame_cnt !== mfc) begin
      n_bad++;
      $display("FAIL %s frame_cnt: got %h want %h", name, frame_cnt, mfc);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({tx_data, tx_en, busy, frame_cnt, overrun_cnt} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got tx_data=%b tx_en=%b busy=%b frame_cnt=%h overrun=%h want all 0",
               tx_data, tx_en, busy, frame_cnt, overrun_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    wr(16'h1234); wr(16'h5678); wr(16'h9ABC); wr(16'hDEF0);
    run_frame("basic", 1'b0, 16'h0, -1, 16'h0);
    check_word("basic_seq_field", rx[1], 16'h0000);
    check_word("basic_checksum", rx[6], 16'hE258);
    check_word("basic_frame_cnt_after", frame_cnt, 16'h0001);
  endtask

  task automatic test_second_tick();
    repeat (500 - TOTAL - 1) step();
    run_frame("second", 1'b0, 16'h0, -1, 16'h0);
    check_word("second_seq_field", rx[1], 16'h0001);
    check_word("second_checksum", rx[6], 16'hE259);
    check_word("second_overrun", {8'h0, overrun_cnt}, 16'h0000);
  endtask

  task automatic test_snapshot();
    run_frame("snap_inflight", 1'b1, 16'hAAAA, 40, 16'h5555);
    check_word("snap_inflight_w0", rx[2], 16'h1234);
    check_word("snap_inflight_w1", rx[3], 16'h5678);
    run_frame("snap_next", 1'b0, 16'h0, -1, 16'h0);
    check_word("snap_next_w0", rx[2], 16'hAAAA);
    check_word("snap_next_w1", rx[3], 16'h5555);
  endtask

  task automatic test_overrun();
    run_ticks("overrun", 114, 1'b0);
    check_word("overrun_two", {8'h0, overrun_cnt}, 16'h0002);
    run_ticks("saturate", 300, 1'b1);
    check_word("overrun_sat", {8'h0, overrun_cnt}, 16'h00FF);
  endtask

  task automatic test_wrap();
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    mfc = 16'hFFFF;
    run_frame("wrap_ffff", 1'b0, 16'h0, -1, 16'h0);
    check_word("wrap_seq_ffff", rx[1], 16'hFFFF);
    run_frame("wrap_0000", 1'b0, 16'h0, -1, 16'h0);
    check_word("wrap_seq_0000", rx[1], 16'h0000);
  endtask

  task automatic test_reset_midframe();
    tx_flag = 1'b1;
    step();
    tx_flag = 1'b0;
    repeat (60) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_en, tx_data, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_lines: got tx_en=%b tx_data=%b busy=%b want 0 0 0", tx_en, tx_data, busy);
    end
    n_cmp++;
    if ({frame_cnt, overrun_cnt} !== 24'd0) begin
      n_bad++;
      $display("FAIL midreset_counters: got frame_cnt=%h overrun=%h want 0 0", frame_cnt, overrun_cnt);
    end
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (tx_en !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_resume: got tx_en=%b want 0", tx_en);
    end
    run_frame("post_reset", 1'b0, 16'h0, -1, 16'h0);
    check_word("post_reset_seq", rx[1], 16'h0000);
    check_word("post_reset_w0", rx[2], 16'h0000);
    check_word("post_reset_checksum", rx[6], 16'h0000);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++) wr(16'($urandom));
      repeat ($urandom_range(0, 20)) step();
      run_frame("random", 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 150), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_second_tick();
    test_snapshot();
    test_overrun();
    test_wrap();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lvds_frame_tx.md
Name: lvds_frame_tx

Overview:
- Downstream consumer of the 100 kHz transmit tick (tx_flag) generated in the lvds_clk domain.
- Holds the most recent N_WORDS 16-bit payload words in a small circular buffer.
- On each tick, snapshots the buffer and serialises one framed packet MSB-first onto a single LVDS data line with an enable strobe.
- Tracks the frame sequence number and counts ticks lost while a frame is still in flight.

Parameters:
- N_WORDS, 4, number of 16-bit payload words per frame; legal range 1..16.
- SYNC_WORD, 16'hEB90, frame sync pattern sent first.

Ports:
- lvds_clk  input  1  single clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- tx_flag  input  1  one-cycle start tick, synchronous to lvds_clk.
- data_in  input  16  payload word to store.
- data_wr  input  1  write strobe for data_in.
- tx_data  output  1  serial bit, MSB-first.
- tx_en  output  1  high while tx_data carries a valid frame bit.
- busy  output  1  frame in progress.
- frame_cnt  output  16  sequence number of the next frame to send.
- overrun_cnt  output  8  saturating count of ticks dropped while busy.

Behaviour:
- Reset (async, rst_n low) values:
  - tx_data=0, tx_en=0, busy=0, frame_cnt=0, overrun_cnt=0.
  - wr_ptr=0, all buffer words 0, state IDLE.
- Buffer:
  - On data_wr, buf[wr_ptr] <= data_in.
  - wr_ptr increments and wraps N_WORDS-1 -> 0.
  - Writes are accepted in every state and never stall.
- Frame format: 16*(N_WORDS+3) bits, 112 for the default, sent in this order:
  - SYNC_WORD
  - frame_cnt
  - buf[0]..buf[N_WORDS-1] from the snapshot
  - checksum
- Checksum: (frame_cnt + sum of snapshot words) mod 2^16; SYNC_WORD is excluded.
- Snapshot:
  - All buffer words and frame_cnt are copied into a shift/holding register on the cycle tx_flag is accepted.
  - A data_wr in that same cycle updates the buffer but not the snapshot.
  - Later writes never alter a frame already in flight.
- FSM states: IDLE, SEND.
  - IDLE: on tx_flag=1, go to SEND, load the snapshot, and set the bit counter to total_bits-1.
  - SEND: drive one bit per cycle. When the counter reaches 0, return to IDLE on the next edge.
- Timing:
  - tx_flag seen high at edge k: first bit (MSB of SYNC_WORD) appears on tx_data with tx_en=1 and busy=1 after edge k.
  - The last checksum bit is driven during the cycle after edge k+total_bits-1.
  - tx_en and busy fall after edge k+total_bits.
  - tx_data returns to 0 whenever tx_en=0.
- frame_cnt increments (wrapping 0xFFFF -> 0) at the acceptance edge; the frame carries the pre-increment value. A frame carrying 0xFFFF is followed by 0x0000.
- Overrun:
  - tx_flag=1 while busy=1, including the cycle carrying the last bit, is dropped; the frame is not restarted.
  - overrun_cnt increments and saturates at 0xFF.
  - A tick in the first cycle after busy falls is accepted normally.
- Checksum arithmetic: 16-bit accumulation, carry discarded; computed from the snapshot before or during SEND, and final by the time the checksum field starts.
- Reset mid-frame: tx_en drops immediately (asynchronously), the frame is abandoned, all state clears, and no partial checksum is emitted afterwards.
- At the 100 kHz period (500 cycles), the default frame (112 bits) always completes before the next tick; overrun only occurs with abnormal tick spacing.

Test Plan:
- Reset, then write 0x1234, 0x5678, 0x9ABC, 0xDEF0, then pulse tx_flag -> 112 bits: EB90, 0000, 1234, 5678, 9ABC, DEF0, E258; tx_en high exactly 112 cycles, starting the cycle after the tick; frame_cnt=1 afterwards.
- Same buffer, second tick 500 cycles later -> frame_cnt field 0001, checksum E259; overrun_cnt stays 0.
- Write 0xAAAA on the tick cycle and 0x5555 mid-frame -> in-flight payload unchanged; next frame contains 0xAAAA in buf[0] and 0x5555 in buf[1].
- Ticks at cycles 0, 50 and 111 relative to the first -> one frame only, overrun_cnt=2; a tick 113 cycles after the first starts a new frame.
- Force 300 overrun ticks -> overrun_cnt saturates at 0xFF. Preload 0xFFFF frames -> frame carrying FFFF is followed by 0000.
- Assert rst_n low at bit 60 of a frame -> tx_en/tx_data go to 0 immediately, counters clear; the next tick after release sends a frame with frame_cnt=0 and zero payload.
